// File: rtl/deslocador_barril_pipe_if.sv
// Handshake bundle for the pipelined barrel shifter: operation in, result out.
interface deslocador_barril_pipe_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned TAG_W = 4
) ();
   localparam int unsigned SHW = $clog2(WIDTH);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_amt;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAG_W-1:0] out_tag;
   logic             out_carry;
   logic             out_zero;
   logic             out_err;

   // Producer/consumer side (drives operations, takes results)
   modport master (
      output in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_data, out_tag, out_carry, out_zero, out_err
   );

   // Shifter side
   modport slave (
      input  in_valid, in_data, in_amt, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_data, out_tag, out_carry, out_zero, out_err
   );
endinterface

// File: rtl/deslocador_barril_pipe.sv
// Pipelined shift/rotate unit. Each stage applies its own slice of the shift
// amount; the last stage's registers drive the result port directly.
module deslocador_barril_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   deslocador_barril_pipe_if.slave bus
);
   localparam int unsigned SHW   = $clog2(WIDTH);
   localparam int unsigned CHUNK = (SHW + STAGES - 1) / STAGES;
   localparam int unsigned LAST  = STAGES - 1;

   typedef enum logic [2:0] {
      OP_SLL = 3'b000,
      OP_SRL = 3'b001,
      OP_SRA = 3'b010,
      OP_ROL = 3'b011,
      OP_ROR = 3'b100,
      OP_SLA = 3'b101
   } op_e;

   // Amount bits handled by stage s: [s*CHUNK, (s+1)*CHUNK) clipped to SHW.
   function automatic logic [SHW-1:0] stage_mask(input int unsigned s);
      logic [SHW-1:0] m;
      m = '0;
      for (int unsigned b = 0; b < SHW; b++) begin
         if (b >= s * CHUNK && b < (s + 1) * CHUNK) m[b] = 1'b1;
      end
      return m;
   endfunction

   // One partial shift. Carry is the last bit pushed out; a zero partial
   // amount leaves the running carry untouched, so chaining partial shifts
   // yields the carry of the full shift.
   function automatic logic [WIDTH:0] shift_step(
      input logic [WIDTH-1:0] d,
      input logic             c,
      input logic [2:0]       op,
      input logic [SHW-1:0]   a
   );
      logic [WIDTH-1:0] r;
      logic             co;
      logic [SHW-1:0]   neg_a;
      logic [SHW-1:0]   a_m1;
      logic [WIDTH-2:0] low;
      r     = d;
      co    = c;
      neg_a = -a;             // WIDTH - a for a > 0
      a_m1  = a - SHW'(1);
      low   = d[WIDTH-2:0] << a;
      if (a != '0) begin
         case (op)
            OP_SLL: begin r = d << a;                        co = d[neg_a]; end
            OP_SRL: begin r = d >> a;                        co = d[a_m1];  end
            OP_SRA: begin r = $signed(d) >>> a;              co = d[a_m1];  end
            OP_ROL: begin r = (d << a) | (d >> neg_a);       co = d[neg_a]; end
            OP_ROR: begin r = (d >> a) | (d << neg_a);       co = d[a_m1];  end
            OP_SLA: begin r = {d[WIDTH-1], low};             co = d[~a];    end
            default: ;
         endcase
      end
      return {co, r};
   endfunction

   logic [STAGES-1:0] valid_q, valid_d, take;
   logic [WIDTH-1:0]  data_q  [STAGES];
   logic [WIDTH-1:0]  data_d  [STAGES];
   logic [SHW-1:0]    rem_q   [STAGES];
   logic [SHW-1:0]    rem_d   [STAGES];
   logic [2:0]        op_q    [STAGES];
   logic [2:0]        op_d    [STAGES];
   logic [TAG_W-1:0]  tag_q   [STAGES];
   logic [TAG_W-1:0]  tag_d   [STAGES];
   logic              carry_q [STAGES];
   logic              carry_d [STAGES];
   logic              err_q   [STAGES];
   logic              err_d   [STAGES];
   logic              zero_q, zero_d;

   logic              src_valid [STAGES];
   logic [WIDTH-1:0]  src_data  [STAGES];
   logic [SHW-1:0]    src_rem   [STAGES];
   logic [2:0]        src_op    [STAGES];
   logic [TAG_W-1:0]  src_tag   [STAGES];
   logic              src_carry [STAGES];
   logic              src_err   [STAGES];

   // A stage may load when it or any stage downstream is empty, or the consumer drains.
   always_comb begin
      logic chain;
      chain = bus.out_ready;
      for (int unsigned i = 0; i < STAGES; i++) begin
         chain = chain || !valid_q[LAST - i];
         take[LAST - i] = chain;
      end
   end

   assign bus.in_ready = !flush && take[0];

   // Feed each stage from its upstream neighbour (stage 0 from the input port).
   always_comb begin
      src_valid[0] = bus.in_valid;
      src_data[0]  = bus.in_data;
      src_rem[0]   = bus.in_amt;
      src_op[0]    = bus.in_op;
      src_tag[0]   = bus.in_tag;
      src_carry[0] = 1'b0;
      src_err[0]   = bus.in_op[2] & bus.in_op[1];
      for (int unsigned s = 1; s < STAGES; s++) begin
         src_valid[s] = valid_q[s-1];
         src_data[s]  = data_q[s-1];
         src_rem[s]   = rem_q[s-1];
         src_op[s]    = op_q[s-1];
         src_tag[s]   = tag_q[s-1];
         src_carry[s] = carry_q[s-1];
         src_err[s]   = err_q[s-1];
      end
   end

   // Next state of every stage: hold, load and apply this stage's amount slice, or flush.
   always_comb begin
      logic [WIDTH:0] res;
      res     = '0;
      valid_d = valid_q;
      zero_d  = zero_q;
      for (int unsigned s = 0; s < STAGES; s++) begin
         data_d[s]  = data_q[s];
         rem_d[s]   = rem_q[s];
         op_d[s]    = op_q[s];
         tag_d[s]   = tag_q[s];
         carry_d[s] = carry_q[s];
         err_d[s]   = err_q[s];
         if (flush) begin
            valid_d[s] = 1'b0;
         end else if (take[s]) begin
            valid_d[s] = src_valid[s];
            if (src_valid[s]) begin
               res        = shift_step(src_data[s], src_carry[s], src_op[s],
                                       src_rem[s] & stage_mask(s));
               data_d[s]  = res[WIDTH-1:0];
               carry_d[s] = res[WIDTH];
               rem_d[s]   = src_rem[s] & ~stage_mask(s);
               op_d[s]    = src_op[s];
               tag_d[s]   = src_tag[s];
               err_d[s]   = src_err[s];
            end
         end
      end
      if (!flush && take[LAST] && src_valid[LAST]) zero_d = (data_d[LAST] == '0);
   end

   // Stage registers; reset empties the pipe and zeroes the result port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         zero_q  <= 1'b0;
         for (int unsigned s = 0; s < STAGES; s++) begin
            data_q[s]  <= '0;
            rem_q[s]   <= '0;
            op_q[s]    <= '0;
            tag_q[s]   <= '0;
            carry_q[s] <= 1'b0;
            err_q[s]   <= 1'b0;
         end
      end else begin
         valid_q <= valid_d;
         zero_q  <= zero_d;
         for (int unsigned s = 0; s < STAGES; s++) begin
            data_q[s]  <= data_d[s];
            rem_q[s]   <= rem_d[s];
            op_q[s]    <= op_d[s];
            tag_q[s]   <= tag_d[s];
            carry_q[s] <= carry_d[s];
            err_q[s]   <= err_d[s];
         end
      end
   end

   assign bus.out_valid = valid_q[LAST];
   assign bus.out_data  = data_q[LAST];
   assign bus.out_tag   = tag_q[LAST];
   assign bus.out_carry = carry_q[LAST];
   assign bus.out_zero  = zero_q;
   assign bus.out_err   = err_q[LAST];
endmodule
